led_display_capture: RTL and testbench

LED_DISPLAY_CAPTURE -- requirements
Module: led_display_capture

---
 rtl/led_display_capture_pkg.sv | 52 +++++
 rtl/led_display_capture_seg7_decode.sv | 36 +++
 rtl/led_display_capture.sv | 208 ++++++++++++++++++++
 tb/tb_led_display_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_display_capture_pkg.sv
// Shared definitions for the multiplexed 7-segment clock display.
// Holds the segment codes (bit7=a .. bit1=g, bit0=dp, active high),
// the digit-position indices used by both the display driver and the
// capture block, the scan FSM state type and small mask helpers.
package led_display_capture_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Digit positions: enable-mask bit n and time_bcd nibble n
    localparam int unsigned DIGIT_SEC_ONES  = 0;
    localparam int unsigned DIGIT_SEC_TENS  = 1;
    localparam int unsigned DIGIT_MIN_ONES  = 2;
    localparam int unsigned DIGIT_MIN_TENS  = 3;
    localparam int unsigned DIGIT_HOUR_ONES = 4;
    localparam int unsigned DIGIT_HOUR_TENS = 5;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_SETTLE,
        SCAN_SAMPLED
    } scan_state_e;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] mask);
        return (mask != '0) && ((mask & (mask - 6'd1)) == '0);
    endfunction

    // Position of the set bit in a one-hot digit mask
    function automatic logic [2:0] digit_index(input logic [NUM_DIGITS-1:0] mask);
        logic [2:0] idx;
        idx = '0;
        if (mask[DIGIT_SEC_ONES])  idx = 3'(DIGIT_SEC_ONES);
        if (mask[DIGIT_SEC_TENS])  idx = 3'(DIGIT_SEC_TENS);
        if (mask[DIGIT_MIN_ONES])  idx = 3'(DIGIT_MIN_ONES);
        if (mask[DIGIT_MIN_TENS])  idx = 3'(DIGIT_MIN_TENS);
        if (mask[DIGIT_HOUR_ONES]) idx = 3'(DIGIT_HOUR_ONES);
        if (mask[DIGIT_HOUR_TENS]) idx = 3'(DIGIT_HOUR_TENS);
        return idx;
    endfunction

endpackage

// File: rtl/led_display_capture_seg7_decode.sv
// seg7_decode: combinational 7-segment to BCD decoder.
// Ports:
//   seg_ag     in  [6:0] segments a..g (bit6=a .. bit0=g), dp excluded
//   digit      out [3:0] decoded BCD value (0 when blank or illegal)
//   is_blank   out       all segments off
//   is_illegal out       pattern is neither a digit 0-9 nor blank
module seg7_decode
    import led_display_capture_pkg::*;
(
    input  logic [6:0] seg_ag,
    output logic [3:0] digit,
    output logic       is_blank,
    output logic       is_illegal
);

    always_comb begin
        digit      = '0;
        is_blank   = 1'b0;
        is_illegal = 1'b0;
        case (seg_ag)
            SEG_0[7:1]:     digit = 4'd0;
            SEG_1[7:1]:     digit = 4'd1;
            SEG_2[7:1]:     digit = 4'd2;
            SEG_3[7:1]:     digit = 4'd3;
            SEG_4[7:1]:     digit = 4'd4;
            SEG_5[7:1]:     digit = 4'd5;
            SEG_6[7:1]:     digit = 4'd6;
            SEG_7[7:1]:     digit = 4'd7;
            SEG_8[7:1]:     digit = 4'd8;
            SEG_9[7:1]:     digit = 4'd9;
            SEG_BLANK[7:1]: is_blank = 1'b1;
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/led_display_capture.sv
// led_display_capture: snoops a multiplexed 6-digit 7-segment clock display
// and reassembles the shown time as HH-MM-SS BCD.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   display_led_segments [7:0] segment bus, bit7=a .. bit1=g, bit0=dp
//   display_led_enable_mask[5:0] one-hot digit enable (5-4 hh, 3-2 mm, 1-0 ss)
//   time_bcd [23:0]            last complete frame, nibble n = digit n
//   blank_mask [5:0]           digits that were dark in the last frame
//   dp_mask [5:0]              decimal points of the last frame
//   frame_valid                one-cycle pulse on output update
//   time_changed               pulse with frame_valid when time_bcd changed
//   decode_error               sticky: illegal pattern or multi-bit mask
//   stale                      no frame for TIMEOUT_CYCLES cycles
// Build option: define LED_DISPLAY_CAPTURE_DP_EN to capture decimal points;
// otherwise dp_mask is tied low and bit0 of the segment bus is ignored.
module led_display_capture
    import led_display_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  display_led_segments,
    input  logic [5:0]  display_led_enable_mask,
    output logic [23:0] time_bcd,
    output logic [5:0]  blank_mask,
    output logic [5:0]  dp_mask,
    output logic        frame_valid,
    output logic        time_changed,
    output logic        decode_error,
    output logic        stale
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam bit SETTLE_IMMEDIATE = (SETTLE_CYCLES <= 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TIMEOUT_MAX = TO_W'(TIMEOUT_CYCLES);

    // Input registers and change detection
    logic [7:1]            seg_ag_q;
    logic [NUM_DIGITS-1:0] mask_q, track_q;

    // Scan FSM
    scan_state_e           state_q, state_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic                  sample, mask_err;

    // Staging and outputs
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [23:0]           stage_bcd_q, stage_bcd_d;
    logic [NUM_DIGITS-1:0] stage_blank_q, stage_blank_d;
    logic [23:0]           time_bcd_q, time_bcd_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  fv_q, fv_d;
    logic                  tc_q, tc_d;
    logic                  err_q, err_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

    logic                  changed, frame_done;
    logic [2:0]            digit_idx;
    logic [3:0]            dec_digit;
    logic                  dec_blank, dec_illegal;

    seg7_decode u_decode (
        .seg_ag     (seg_ag_q),
        .digit      (dec_digit),
        .is_blank   (dec_blank),
        .is_illegal (dec_illegal)
    );

    assign changed    = (mask_q != track_q);
    assign digit_idx  = digit_index(mask_q);
    assign frame_done = (seen_q == '1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample   = 1'b0;
        mask_err = 1'b0;
        if (changed) begin
            if (mask_q == '0) begin
                state_d = SCAN_IDLE;
            end else if (!is_onehot(mask_q)) begin
                state_d  = SCAN_IDLE;
                mask_err = 1'b1;
            end else if (SETTLE_IMMEDIATE) begin
                state_d = SCAN_SAMPLED;
                sample  = 1'b1;
            end else begin
                state_d = SCAN_SETTLE;
                cnt_d   = SETTLE_W'(1);
            end
        end else if (state_q == SCAN_SETTLE) begin
            if (cnt_q == SETTLE_LAST) begin
                state_d = SCAN_SAMPLED;
                sample  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        stage_bcd_d   = stage_bcd_q;
        stage_blank_d = stage_blank_q;
        time_bcd_d    = time_bcd_q;
        blank_d       = blank_q;
        fv_d          = frame_done;
        tc_d          = frame_done && (stage_bcd_q != time_bcd_q);
        err_d         = err_q | mask_err | (sample & dec_illegal);
        // A digit captured in the completion cycle starts the next frame
        seen_d        = frame_done ? '0 : seen_q;
        to_cnt_d      = (to_cnt_q == TIMEOUT_MAX) ? to_cnt_q : to_cnt_q + 1'b1;

        if (sample && !dec_illegal) begin
            seen_d = seen_d | mask_q;
            stage_blank_d[digit_idx] = dec_blank;
            if (!dec_blank) begin
                stage_bcd_d[{digit_idx, 2'b00} +: 4] = dec_digit;
            end
        end

        if (frame_done) begin
            time_bcd_d = stage_bcd_q;
            blank_d    = stage_blank_q;
            to_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_ag_q      <= '0;
            mask_q        <= '0;
            track_q       <= '0;
            state_q       <= SCAN_IDLE;
            cnt_q         <= '0;
            seen_q        <= '0;
            stage_bcd_q   <= '0;
            stage_blank_q <= '0;
            time_bcd_q    <= '0;
            blank_q       <= '0;
            fv_q          <= 1'b0;
            tc_q          <= 1'b0;
            err_q         <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            seg_ag_q      <= display_led_segments[7:1];
            mask_q        <= display_led_enable_mask;
            track_q       <= mask_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            stage_bcd_q   <= stage_bcd_d;
            stage_blank_q <= stage_blank_d;
            time_bcd_q    <= time_bcd_d;
            blank_q       <= blank_d;
            fv_q          <= fv_d;
            tc_q          <= tc_d;
            err_q         <= err_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

`ifdef LED_DISPLAY_CAPTURE_DP_EN
    logic                  seg_dp_q;
    logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;

    always_comb begin
        stage_dp_d = stage_dp_q;
        dp_d       = dp_q;
        if (sample && !dec_illegal) begin
            stage_dp_d[digit_idx] = seg_dp_q;
        end
        if (frame_done) begin
            dp_d = stage_dp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_dp_q   <= 1'b0;
            stage_dp_q <= '0;
            dp_q       <= '0;
        end else begin
            seg_dp_q   <= display_led_segments[0];
            stage_dp_q <= stage_dp_d;
            dp_q       <= dp_d;
        end
    end

    assign dp_mask = dp_q;
`else
    logic unused_seg_dp;
    assign unused_seg_dp = display_led_segments[0];
    assign dp_mask       = '0;
`endif

    assign time_bcd     = time_bcd_q;
    assign blank_mask   = blank_q;
    assign frame_valid  = fv_q;
    assign time_changed = tc_q;
    assign decode_error = err_q;
    assign stale        = (to_cnt_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_led_display_capture.sv
`timescale 1ns/1ps
module tb_led_display_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 300;
    localparam int unsigned HOLD    = 8;
    localparam int          NONE    = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  seg;
    logic [5:0]  mask;
    logic [23:0] time_bcd;
    logic [5:0]  blank_mask;
    logic [5:0]  dp_mask;
    logic        frame_valid;
    logic        time_changed;
    logic        decode_error;
    logic        stale;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    int unsigned fv_count     = 0;
    logic        tc_at_fv     = 1'b0;
    int unsigned n0;

`ifdef LED_DISPLAY_CAPTURE_DP_EN
    localparam logic [5:0] DP_EXP = 6'b001010;
`else
    localparam logic [5:0] DP_EXP = 6'b000000;
`endif

    always #5 clk = ~clk;

    led_display_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .display_led_segments    (seg),
        .display_led_enable_mask (mask),
        .time_bcd                (time_bcd),
        .blank_mask              (blank_mask),
        .dp_mask                 (dp_mask),
        .frame_valid             (frame_valid),
        .time_changed            (time_changed),
        .decode_error            (decode_error),
        .stale                   (stale)
    );

    // Frame pulses are counted away from the active edge
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count = fv_count + 1;
            tc_at_fv = time_changed;
        end
    end

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0: return 8'hFC;
            4'd1: return 8'h60;
            4'd2: return 8'hDA;
            4'd3: return 8'hF2;
            4'd4: return 8'h66;
            4'd5: return 8'hB6;
            4'd6: return 8'hBE;
            4'd7: return 8'hE0;
            4'd8: return 8'hFE;
            default: return 8'hF6;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] m, input logic [7:0] s, input int unsigned n);
        mask = m;
        seg  = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scan digits 5 down to 0, then hold the display dark briefly
    task automatic scan(input logic [23:0] bcd, input logic [5:0] blank, input logic [5:0] dp,
                        input int short_digit, input int bad_digit);
        logic [7:0] s;
        for (int d = 5; d >= 0; d--) begin
            s    = blank[d] ? 8'h00 : seg_code(bcd[d*4 +: 4]);
            if (d == bad_digit) s = 8'h02;
            s[0] = dp[d];
            drive(6'(1 << d), s, (d == short_digit) ? SETTLE - 1 : HOLD);
        end
        drive('0, '0, 4);
    endtask

    initial begin
        reset = 1'b1;
        mask  = '0;
        seg   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_eq("rst_time",  32'(time_bcd), 32'h0);
        check_eq("rst_blank", 32'(blank_mask), 32'h0);
        check_eq("rst_dp",    32'(dp_mask), 32'h0);
        check_eq("rst_fv",    32'(frame_valid), 32'h0);
        check_eq("rst_tc",    32'(time_changed), 32'h0);
        check_eq("rst_err",   32'(decode_error), 32'h0);
        check_eq("rst_stale", 32'(stale), 32'h0);

        // First frame 12:34:56
        n0 = fv_count;
        scan(24'h123456, 6'b0, 6'b0, NONE, NONE);
        check_eq("f1_frames", fv_count - n0, 1);
        check_eq("f1_tc",     32'(tc_at_fv), 32'h1);
        check_eq("f1_time",   32'(time_bcd), 32'h123456);
        check_eq("f1_blank",  32'(blank_mask), 32'h0);
        check_eq("f1_err",    32'(decode_error), 32'h0);

        // Same frame again, then 12:34:57
        n0 = fv_count;
        scan(24'h123456, 6'b0, 6'b0, NONE, NONE);
        check_eq("f2_frames", fv_count - n0, 1);
        check_eq("f2_tc",     32'(tc_at_fv), 32'h0);
        n0 = fv_count;
        scan(24'h123457, 6'b0, 6'b0, NONE, NONE);
        check_eq("f3_frames", fv_count - n0, 1);
        check_eq("f3_tc",     32'(tc_at_fv), 32'h1);
        check_eq("f3_time",   32'(time_bcd), 32'h123457);

        // Hours dark: nibbles 5-4 keep the previous 1,2
        n0 = fv_count;
        scan(24'h003457, 6'b110000, 6'b0, NONE, NONE);
        check_eq("blk_frames", fv_count - n0, 1);
        check_eq("blk_mask",   32'(blank_mask), 32'h30);
        check_eq("blk_time",   32'(time_bcd), 32'h123457);
        check_eq("blk_tc",     32'(tc_at_fv), 32'h0);

        // Digit 2 held one cycle short of settling: no frame
        n0 = fv_count;
        scan(24'h123457, 6'b0, 6'b0, 2, NONE);
        check_eq("short_frames", fv_count - n0, 0);
        check_eq("short_stale",  32'(stale), 32'h0);

        // Long idle -> stale; next scan completes at digit 2 and clears it
        drive('0, '0, TIMEOUT + 20);
        check_eq("idle_stale", 32'(stale), 32'h1);
        n0 = fv_count;
        scan(24'h123457, 6'b0, 6'b0, NONE, NONE);
        check_eq("recov_frames", fv_count - n0, 1);
        check_eq("recov_stale",  32'(stale), 32'h0);
        check_eq("recov_blank",  32'(blank_mask), 32'h0);

        // Partial capture of digits 2..0 as 9,8,7, then reset mid-frame
        n0 = fv_count;
        drive(6'b000100, seg_code(4'd9), HOLD);
        drive(6'b000010, seg_code(4'd8), HOLD);
        drive(6'b000001, seg_code(4'd7), HOLD);
        check_eq("part_frames", fv_count - n0, 0);
        reset = 1'b1;
        drive('0, '0, 2);
        reset = 1'b0;
        check_eq("mid_rst_time", 32'(time_bcd), 32'h0);
        n0 = fv_count;
        scan(24'h123456, 6'b0, 6'b001010, NONE, NONE);
        check_eq("post_rst_frames", fv_count - n0, 1);
        check_eq("post_rst_time",   32'(time_bcd), 32'h123456);
        check_eq("post_rst_tc",     32'(tc_at_fv), 32'h1);
        check_eq("post_rst_dp",     32'(dp_mask), 32'(DP_EXP));

        // Two-hot mask sets the sticky error
        check_eq("pre_err", 32'(decode_error), 32'h0);
        drive(6'b000011, seg_code(4'd8), HOLD);
        drive('0, '0, 2);
        check_eq("mask_err", 32'(decode_error), 32'h1);
        n0 = fv_count;
        scan(24'h123456, 6'b0, 6'b0, NONE, NONE);
        check_eq("err_good_frames", fv_count - n0, 1);
        check_eq("err_sticky",      32'(decode_error), 32'h1);

        // Illegal segment pattern on digit 3 is discarded
        reset = 1'b1;
        drive('0, '0, 2);
        reset = 1'b0;
        check_eq("err_rst", 32'(decode_error), 32'h0);
        n0 = fv_count;
        scan(24'h123456, 6'b0, 6'b0, NONE, 3);
        check_eq("illegal_err",    32'(decode_error), 32'h1);
        check_eq("illegal_frames", fv_count - n0, 0);
        check_eq("illegal_time",   32'(time_bcd), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
